pad_input_conditioner: RTL and testbench

Conditions the raw game-controller joystick (player 0), the player-1 direction switches and the pause button before they reach the processor's direction and pause inputs. Each input is synchronised and debounced. Each player's direction is held as a one-hot latched heading, as the maze game needs, and the pause button becomes a toggle level plus a one-cycle pulse. The block sits between the board pins and the processor wrapper, in place of the raw wiring.

---
 rtl/pad_input_conditioner_pkg.sv | 19 +
 rtl/pad_input_conditioner_debounce.sv | 46 ++++
 rtl/pad_input_conditioner.sv | 103 ++++++++++
 tb/tb_pad_input_conditioner.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pad_input_conditioner_pkg.sv
// rtl/pad_input_conditioner_pkg.sv - shared direction indices, defaults and helpers for pad conditioning
package pad_defs;

    // Bit positions in a heading vector, matching the processor's up/right/down/left order
    localparam int DIR_UP    = 0;
    localparam int DIR_RIGHT = 1;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 3;

    // 10 ms at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_CNT_W           = 20;

    // True when exactly one direction bit is set
    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/pad_input_conditioner_debounce.sv
// rtl/pad_input_conditioner_debounce.sv - two-flop synchroniser plus stability-count debouncer for one raw bit
module debounce_bit
    import pad_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clock,
    input  logic resetn,
    input  logic raw,
    output logic stable
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic             sync;
    logic [CNT_W-1:0] count;

    // Bring the asynchronous pin into the clock domain
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // Accept a new level only after it has differed from stable for DEBOUNCE_CYCLES cycles in a row
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stable <= 1'b0;
            count  <= '0;
        end else if (sync == stable) begin
            count <= '0;
        end else if (count == LAST_COUNT) begin
            stable <= sync;
            count  <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pad_input_conditioner.sv
// rtl/pad_input_conditioner.sv - debounced, latched joystick headings and pause toggle for the maze processor
module pad_input_conditioner
    import pad_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       joy_n,
    input  logic       joy_e,
    input  logic       joy_s,
    input  logic       joy_w,
    input  logic       sw_up,
    input  logic       sw_right,
    input  logic       sw_down,
    input  logic       sw_left,
    input  logic       pause_btn,
    input  logic       dir_clear,
    output logic [3:0] p0_dir,
    output logic [3:0] p1_dir,
    output logic [1:0] dir_change,
    output logic       paused,
    output logic       pause_pulse
);

    logic [8:0] raw_vec;
    logic [8:0] deb;
    logic [3:0] p0_req;
    logic [3:0] p1_req;
    logic [3:0] p0_prev;
    logic [3:0] p1_prev;
    logic       pause_prev;

    assign raw_vec = {pause_btn, sw_left, sw_down, sw_right, sw_up, joy_w, joy_s, joy_e, joy_n};

    for (genvar i = 0; i < 9; i++) begin : g_deb
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clock (clock),
            .resetn(resetn),
            .raw   (raw_vec[i]),
            .stable(deb[i])
        );
    end

    // Map debounced pins onto heading bit positions for each player
    always_comb begin
        p0_req            = '0;
        p1_req            = '0;
        p0_req[DIR_UP]    = deb[0];
        p0_req[DIR_RIGHT] = deb[1];
        p0_req[DIR_DOWN]  = deb[2];
        p0_req[DIR_LEFT]  = deb[3];
        p1_req[DIR_UP]    = deb[4];
        p1_req[DIR_RIGHT] = deb[5];
        p1_req[DIR_DOWN]  = deb[6];
        p1_req[DIR_LEFT]  = deb[7];
    end

    // Latch a heading only on a single clean direction; clear beats everything, pause freezes
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            p0_dir <= '0;
            p1_dir <= '0;
        end else if (dir_clear) begin
            p0_dir <= '0;
            p1_dir <= '0;
        end else if (!paused) begin
            if (is_one_hot(p0_req)) p0_dir <= p0_req;
            if (is_one_hot(p1_req)) p1_dir <= p1_req;
        end
    end

    // Flag a heading change one cycle after the register moved
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            p0_prev    <= '0;
            p1_prev    <= '0;
            dir_change <= '0;
        end else begin
            p0_prev    <= p0_dir;
            p1_prev    <= p1_dir;
            dir_change <= {p1_dir != p1_prev, p0_dir != p0_prev};
        end
    end

    // Toggle pause and pulse once on each debounced press; release is ignored
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pause_prev  <= 1'b0;
            paused      <= 1'b0;
            pause_pulse <= 1'b0;
        end else begin
            pause_prev  <= deb[8];
            pause_pulse <= deb[8] & ~pause_prev;
            paused      <= paused ^ (deb[8] & ~pause_prev);
        end
    end

endmodule

// File: tb/tb_pad_input_conditioner.sv
// tb/tb_pad_input_conditioner.sv - scoreboard bench for pad_input_conditioner against a behavioural model
module tb_pad_input_conditioner;

    localparam int DC = 4;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [8:0] raw = 9'h1FF;
    logic       dir_clear = 1'b0;

    logic       joy_n, joy_e, joy_s, joy_w, sw_up, sw_right, sw_down, sw_left, pause_btn;
    logic [3:0] p0_dir, p1_dir;
    logic [1:0] dir_change;
    logic       paused, pause_pulse;

    assign joy_n     = raw[0];
    assign joy_e     = raw[1];
    assign joy_s     = raw[2];
    assign joy_w     = raw[3];
    assign sw_up     = raw[4];
    assign sw_right  = raw[5];
    assign sw_down   = raw[6];
    assign sw_left   = raw[7];
    assign pause_btn = raw[8];

    pad_input_conditioner #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .joy_n      (joy_n),
        .joy_e      (joy_e),
        .joy_s      (joy_s),
        .joy_w      (joy_w),
        .sw_up      (sw_up),
        .sw_right   (sw_right),
        .sw_down    (sw_down),
        .sw_left    (sw_left),
        .pause_btn  (pause_btn),
        .dir_clear  (dir_clear),
        .p0_dir     (p0_dir),
        .p1_dir     (p1_dir),
        .dir_change (dir_change),
        .paused     (paused),
        .pause_pulse(pause_pulse)
    );

    always #5 clock = ~clock;

    logic [10:0] exp_q[$];
    int          compared = 0;
    int          mismatched = 0;
    int          cycle_no = 0;

    // reference model state
    logic [8:0] raw_h[$];
    logic [8:0] m_stable;
    logic       m_pprev, m_paused, m_pulse;
    logic [3:0] m_p0, m_p1, m_p0_old, m_p1_old;

    task automatic model_reset();
        raw_h.delete();
        m_stable = '0;
        m_pprev  = 1'b0;
        m_paused = 1'b0;
        m_pulse  = 1'b0;
        m_p0     = '0;
        m_p1     = '0;
        m_p0_old = '0;
        m_p1_old = '0;
    endtask

    // Evaluate one clock edge from the pin history and push the outputs expected after it
    task automatic step();
        logic [8:0] nxt;
        logic [3:0] d0, d1;
        logic [1:0] chg;
        logic       rise, s, all_diff;
        int         n, idx;
        if (!resetn) begin
            model_reset();
            exp_q.push_back('0);
            return;
        end
        raw_h.push_back(raw);
        if (raw_h.size() > DC + 4) void'(raw_h.pop_front());
        n = raw_h.size();
        // a debounced bit flips once the pin, seen two clocks late, has opposed it for DC edges running
        for (int b = 0; b < 9; b++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DC; j++) begin
                idx = n - 3 - j;
                s = (idx >= 0) ? raw_h[idx][b] : 1'b0;
                if (s == m_stable[b]) all_diff = 1'b0;
            end
            nxt[b] = all_diff ? ~m_stable[b] : m_stable[b];
        end
        d0  = m_stable[3:0];
        d1  = m_stable[7:4];
        chg = {m_p1 != m_p1_old, m_p0 != m_p0_old};
        m_p0_old = m_p0;
        m_p1_old = m_p1;
        if (dir_clear) begin
            m_p0 = '0;
            m_p1 = '0;
        end else if (!m_paused) begin
            if ($countones(d0) == 1) m_p0 = d0;
            if ($countones(d1) == 1) m_p1 = d1;
        end
        rise     = m_stable[8] && !m_pprev;
        m_pprev  = m_stable[8];
        m_paused = m_paused ^ rise;
        m_pulse  = rise;
        m_stable = nxt;
        exp_q.push_back({m_paused, m_pulse, chg, m_p1, m_p0});
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            cycle_no++;
            step();
            #1;
        end
    endtask

    // Async reset taken mid-cycle: outputs drop at once, so this cycle's expectation becomes zero
    task automatic do_reset(input int n);
        resetn = 1'b0;
        model_reset();
        if (exp_q.size() > 0) exp_q[exp_q.size() - 1] = '0;
        cyc(n);
        resetn = 1'b1;
    endtask

    // monitor
    initial begin
        logic [10:0] e, got;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {paused, pause_pulse, dir_change, p1_dir, p0_dir};
                compared++;
                if (got !== e) begin
                    mismatched++;
                    $display("FAIL outputs cycle %0d: got {paused,pulse,chg,p1,p0}=%b expected %b", cycle_no, got, e);
                end
            end
        end
    end

    initial begin
        int k;
        model_reset();
        // reset with every pin high
        raw = 9'h1FF;
        cyc(3);
        raw = 9'h001;
        resetn = 1'b1;
        cyc(12);
        // glitch rejection then a real press
        raw = 9'h000; cyc(8);
        raw = 9'h002; cyc(3);
        raw = 9'h000; cyc(8);
        raw = 9'h002; cyc(10);
        // hold and diagonal
        raw = 9'h001; cyc(10);
        raw = 9'h003; cyc(10);
        raw = 9'h000; cyc(10);
        // pause, ignored input, unpause
        raw = 9'h100; cyc(10);
        raw = 9'h000; cyc(8);
        raw = 9'h080; cyc(10);
        raw = 9'h180; cyc(10);
        raw = 9'h080; cyc(10);
        // clear while a direction is valid
        raw = 9'h004; cyc(5);
        dir_clear = 1'b1; cyc(1);
        dir_clear = 1'b0; cyc(5);
        // reset mid-debounce
        raw = 9'h008; cyc(2);
        do_reset(2);
        cyc(12);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                k = $urandom_range(0, 8);
                raw[k] = ~raw[k];
            end
            dir_clear = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 499) == 0) do_reset($urandom_range(1, 3));
            else cyc(1);
        end
        dir_clear = 1'b0;
        cyc(2);
        @(negedge clock);
        #1;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
